router_fsm: RTL and testbench
=============================

# router_fsm

Control state machine of the 1x3 packet router. It watches the incoming packet stream's header address, valid flag and FIFO status. It then sequences header, payload and parity loading into one of three output FIFOs. It sits between the router's input interface and the register/synchronizer blocks, driving their load, write-enable and busy controls.

## Interface
Parameters: none.
- clock  in  1  system clock, all state changes on rising edge
- resetn  in  1  asynchronous active-low reset
- pkt_valid  in  1  high while header/payload bytes are presented; falls with parity byte
- data_in  in  2  destination address (header bits [1:0]); 0,1,2 valid, 3 invalid
- fifo_full  in  1  addressed FIFO full
- fifo_empty_0 / fifo_empty_1 / fifo_empty_2  in  1 each  per-FIFO empty
- soft_reset_0 / soft_reset_1 / soft_reset_2  in  1 each  per-FIFO timeout soft reset
- parity_done  in  1  parity byte already stored
- low_packet_valid  in  1  pkt_valid fell while FIFO was full
- write_enb_reg  out  1  write enable to register block
- detect_add, ld_state, laf_state, lfd_state, full_state  out  1 each  state indicators
- rst_int_reg  out  1  clear internal parity/low-packet registers
- busy  out  1  input must be held off

## Operation
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
- Address register: captures data_in when state is DECODE_ADDRESS and pkt_valid=1; used by WAIT_TILL_EMPTY and soft-reset selection.
- DECODE_ADDRESS:
  - pkt_valid and addr n∈{0,1,2} with fifo_empty_n=1 → LOAD_FIRST_DATA.
  - pkt_valid, addr valid and that FIFO non-empty → WAIT_TILL_EMPTY.
  - Otherwise, including addr 3, hold.
- LOAD_FIRST_DATA → LOAD_DATA unconditionally.
- LOAD_DATA: fifo_full → FIFO_FULL_STATE; else !pkt_valid → LOAD_PARITY; else hold.
- FIFO_FULL_STATE: !fifo_full → LOAD_AFTER_FULL; else hold.
- LOAD_AFTER_FULL:
  - parity_done → DECODE_ADDRESS.
  - Else low_packet_valid → LOAD_PARITY.
  - Else → LOAD_DATA.
- LOAD_PARITY → CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full → FIFO_FULL_STATE; else → DECODE_ADDRESS.
- WAIT_TILL_EMPTY: fifo_empty of latched address → LOAD_FIRST_DATA; else hold.
- Soft reset: soft_reset_n for the latched address n forces DECODE_ADDRESS on the next edge. It has priority over all transitions and applies in any state. Soft resets of other ports are ignored.
- Outputs (Moore, decoded from state):
  - detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; laf_state=LOAD_AFTER_FULL; full_state=FIFO_FULL_STATE; rst_int_reg=CHECK_PARITY_ERROR.
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.

## Timing
- Reset (resetn=0, asynchronous): state=DECODE_ADDRESS, address register=0, detect_add=1, all other outputs 0. Mid-packet reset aborts immediately.
- Single state register; outputs combinational from it, so zero latency after the clock edge that changes state.
- Minimum packet: DECODE→LFD→LD→LP→CPE→DECODE, 5 cycles for a 1-payload packet with no full condition.
- Simultaneous fifo_full and !pkt_valid in LOAD_DATA: full wins.

## Configuration
- ROUTER_FSM_ASSERT_EN defined: embedded assertions are compiled in. They check:
  - state indicators one-hot-or-zero;
  - write_enb_reg never high in DECODE_ADDRESS;
  - data_in≠3 on each LOAD_FIRST_DATA entry.
- Undefined: no assertion logic; functionality is identical.

## Structure
- Shared package router_pkg: state enumeration typedef, address constants (ADDR_0..ADDR_2, ADDR_INVALID=3).
- Single module; no sub-module warranted. Next-state logic, address latch and output decode are all inline.

## Test plan
- Reset, then pkt_valid=1, data_in=0, fifo_empty_0=1. Drop pkt_valid at cycle 3 → sequence detect_add, lfd_state, ld_state, write_enb (LP), rst_int_reg, detect_add.
- data_in=1, empty. fifo_full=1 during LOAD_DATA → full_state=1, busy=1. Release full with low_packet_valid=1 → laf_state, then LOAD_PARITY.
- data_in=2, full then release with low_packet_valid=0, parity_done=0 → LAF returns to ld_state=1.
- fifo_full=1 in CHECK_PARITY_ERROR → full_state. Release with parity_done=1 → LAF then detect_add.
- data_in=1, fifo_empty_1=0 → WAIT_TILL_EMPTY, busy=1. Assert fifo_empty_1 → lfd_state. Repeat with soft_reset_1=1 → detect_add next cycle.
- data_in=3 with pkt_valid=1 → stays DECODE_ADDRESS. resetn low mid-LOAD_DATA → detect_add=1 immediately.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 packet router control path.
package router_pkg;

  // Controller states; encoding is arbitrary, outputs are decoded by name.
  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;

  // Destination port addresses carried in header bits [1:0].
  localparam logic [1:0] ADDR_0       = 2'd0;
  localparam logic [1:0] ADDR_1       = 2'd1;
  localparam logic [1:0] ADDR_2       = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  // Pick the per-port flag for an address; the invalid address selects nothing.
  function automatic logic sel_port(input logic [1:0] addr, input logic [2:0] flags);
    logic result;
    case (addr)
      ADDR_0:  result = flags[0];
      ADDR_1:  result = flags[1];
      ADDR_2:  result = flags[2];
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// router_fsm: control state machine of the 1x3 packet router.
// Sequences header, payload and parity loading into one of three output
// FIFOs and drives load / write-enable / busy controls.
// Optional build macro: ROUTER_FSM_ASSERT_EN compiles in embedded assertions
// (state indicators one-hot-or-zero, no write in DECODE_ADDRESS, valid
// address on LOAD_FIRST_DATA entry). Functionality is identical either way.
module router_fsm
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       ld_state,
  output logic       laf_state,
  output logic       lfd_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  state_e     state_r;
  state_e     state_next_s;
  logic [1:0] addr_r;
  logic [2:0] empty_vec_s;
  logic [2:0] soft_vec_s;
  logic       hdr_empty_s;   // empty flag of the port named by the incoming header
  logic       hdr_valid_s;   // incoming header names a real port
  logic       latched_empty_s;
  logic       latched_soft_s;

  assign empty_vec_s     = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_vec_s      = {soft_reset_2, soft_reset_1, soft_reset_0};
  assign hdr_valid_s     = (data_in != ADDR_INVALID);
  assign hdr_empty_s     = sel_port(data_in, empty_vec_s);
  assign latched_empty_s = sel_port(addr_r, empty_vec_s);
  assign latched_soft_s  = sel_port(addr_r, soft_vec_s);

  // State register; a reset aborts any packet in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= DECODE_ADDRESS;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Address latch: remember the header destination while decoding.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_r <= ADDR_0;
    end else if ((state_r == DECODE_ADDRESS) && pkt_valid) begin
      addr_r <= data_in;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Next-state logic; a timeout soft reset on the active port overrides all.
  always_comb begin
    state_next_s = state_r;
    if (latched_soft_s) begin
      state_next_s = DECODE_ADDRESS;
    end else begin
      case (state_r)
        DECODE_ADDRESS: begin
          if (pkt_valid && hdr_valid_s && hdr_empty_s) begin
            state_next_s = LOAD_FIRST_DATA;
          end else if (pkt_valid && hdr_valid_s) begin
            state_next_s = WAIT_TILL_EMPTY;
          end else begin
            state_next_s = DECODE_ADDRESS;
          end
        end
        LOAD_FIRST_DATA: state_next_s = LOAD_DATA;
        LOAD_DATA: begin
          // A full FIFO takes precedence over the end of the packet.
          if (fifo_full) begin
            state_next_s = FIFO_FULL_STATE;
          end else if (!pkt_valid) begin
            state_next_s = LOAD_PARITY;
          end else begin
            state_next_s = LOAD_DATA;
          end
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) begin
            state_next_s = LOAD_AFTER_FULL;
          end else begin
            state_next_s = FIFO_FULL_STATE;
          end
        end
        LOAD_AFTER_FULL: begin
          if (parity_done) begin
            state_next_s = DECODE_ADDRESS;
          end else if (low_packet_valid) begin
            state_next_s = LOAD_PARITY;
          end else begin
            state_next_s = LOAD_DATA;
          end
        end
        LOAD_PARITY: state_next_s = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          if (fifo_full) begin
            state_next_s = FIFO_FULL_STATE;
          end else begin
            state_next_s = DECODE_ADDRESS;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (latched_empty_s) begin
            state_next_s = LOAD_FIRST_DATA;
          end else begin
            state_next_s = WAIT_TILL_EMPTY;
          end
        end
        default: state_next_s = DECODE_ADDRESS;
      endcase
    end
  end

  // Moore output decode straight from the state register.
  always_comb begin
    detect_add    = (state_r == DECODE_ADDRESS);
    lfd_state     = (state_r == LOAD_FIRST_DATA);
    ld_state      = (state_r == LOAD_DATA);
    laf_state     = (state_r == LOAD_AFTER_FULL);
    full_state    = (state_r == FIFO_FULL_STATE);
    rst_int_reg   = (state_r == CHECK_PARITY_ERROR);
    write_enb_reg = (state_r == LOAD_DATA) || (state_r == LOAD_PARITY) ||
                    (state_r == LOAD_AFTER_FULL);
    busy          = !((state_r == DECODE_ADDRESS) || (state_r == LOAD_DATA));
  end

`ifdef ROUTER_FSM_ASSERT_EN
  a_ind_onehot0: assert property (@(posedge clock) disable iff (!resetn)
    $onehot0({detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg}));

  a_no_write_in_decode: assert property (@(posedge clock) disable iff (!resetn)
    detect_add |-> !write_enb_reg);

  // The header seen on the decode-to-load transition must name a real port.
  a_lfd_valid_addr: assert property (@(posedge clock) disable iff (!resetn)
    ((state_r == DECODE_ADDRESS) && (state_next_s == LOAD_FIRST_DATA))
      |-> (data_in != ADDR_INVALID));
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Testbench for router_fsm: directed test-plan sequences followed by random
// stimulus, checked cycle by cycle against a behavioural model via a queue.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [1:0] data_in = 2'd0;
  logic       fifo_full = 1'b0;
  logic       fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1, fifo_empty_2 = 1'b1;
  logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
  logic       parity_done = 1'b0;
  logic       low_packet_valid = 1'b0;
  logic       write_enb_reg, detect_add, ld_state, laf_state, lfd_state;
  logic       full_state, rst_int_reg, busy;

  int tests = 0;
  int fails = 0;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done),
    .low_packet_valid(low_packet_valid), .write_enb_reg(write_enb_reg),
    .detect_add(detect_add), .ld_state(ld_state), .laf_state(laf_state),
    .lfd_state(lfd_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Model phases (named by what the router is doing, not by RTL encoding).
  localparam int P_IDLE = 0, P_HDR = 1, P_BODY = 2, P_PAR = 3,
                 P_STALL = 4, P_RESUME = 5, P_WAIT = 6, P_CHK = 7;
  // Expected outputs per phase:
  // {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy}
  logic [7:0] exp_tbl [0:7];
  initial begin
    exp_tbl[P_IDLE]   = 8'b1000_0000;
    exp_tbl[P_HDR]    = 8'b0100_0001;
    exp_tbl[P_BODY]   = 8'b0010_0010;
    exp_tbl[P_PAR]    = 8'b0000_0011;
    exp_tbl[P_STALL]  = 8'b0000_1001;
    exp_tbl[P_RESUME] = 8'b0001_0011;
    exp_tbl[P_WAIT]   = 8'b0000_0001;
    exp_tbl[P_CHK]    = 8'b0000_0101;
  end

  logic [7:0] exp_q [$];
  int         m_phase = P_IDLE;
  int         m_port  = 0;

  function automatic logic [7:0] dut_vec();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            rst_int_reg, write_enb_reg, busy};
  endfunction

  // Reference model: advance one packet-handling step per rising edge.
  always @(posedge clock) begin
    int          nxt;
    logic        empt [0:2];
    logic        srst [0:2];
    empt[0] = fifo_empty_0; empt[1] = fifo_empty_1; empt[2] = fifo_empty_2;
    srst[0] = soft_reset_0; srst[1] = soft_reset_1; srst[2] = soft_reset_2;
    if (!resetn) begin
      m_phase = P_IDLE;
      m_port  = 0;
    end else begin
      nxt = m_phase;
      if (m_port < 3 && srst[m_port]) nxt = P_IDLE;
      else if (m_phase == P_IDLE) begin
        if (pkt_valid && int'(data_in) < 3) nxt = empt[int'(data_in)] ? P_HDR : P_WAIT;
      end
      else if (m_phase == P_HDR) nxt = P_BODY;
      else if (m_phase == P_BODY) nxt = fifo_full ? P_STALL : (pkt_valid ? P_BODY : P_PAR);
      else if (m_phase == P_STALL) nxt = fifo_full ? P_STALL : P_RESUME;
      else if (m_phase == P_RESUME) nxt = parity_done ? P_IDLE : (low_packet_valid ? P_PAR : P_BODY);
      else if (m_phase == P_PAR) nxt = P_CHK;
      else if (m_phase == P_CHK) nxt = fifo_full ? P_STALL : P_IDLE;
      else if (m_phase == P_WAIT) nxt = (m_port < 3 && empt[m_port]) ? P_HDR : P_WAIT;
      if (m_phase == P_IDLE && pkt_valid) m_port = int'(data_in);
      m_phase = nxt;
    end
    exp_q.push_back(exp_tbl[m_phase]);
  end

  // Monitor: outputs are presented every cycle; compare just after the edge.
  always @(posedge clock) begin
    logic [7:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (dut_vec() !== e) begin
        fails++;
        $display("FAIL cycle_outputs t=%0t got=%b expected=%b", $time, dut_vec(), e);
      end
    end
  end

  // Apply one cycle of inputs on the falling edge.
  task automatic drive(input logic pv, input logic [1:0] din, input logic full,
                       input logic [2:0] empt, input logic [2:0] srst,
                       input logic pd, input logic lpv);
    @(negedge clock);
    pkt_valid = pv; data_in = din; fifo_full = full;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = empt;
    {soft_reset_2, soft_reset_1, soft_reset_0} = srst;
    parity_done = pd; low_packet_valid = lpv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic check_now(input string name, input logic [7:0] e);
    tests++;
    if (dut_vec() !== e) begin
      fails++;
      $display("FAIL %s got=%b expected=%b", name, dut_vec(), e);
    end
  endtask

  initial begin
    #2;
    check_now("reset_state", 8'b1000_0000);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    idle(2);

    // Minimal packet to port 0.
    drive(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    idle(3);

    // Port 1: full during payload, released with low_packet_valid.
    drive(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1);
    drive(1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1);
    idle(3);

    // Port 2: full, released without parity/low flags -> back to payload.
    drive(1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    // Simultaneous full and end of packet: full wins.
    drive(1'b0, 2'd2, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0);
    idle(3);

    // Full during parity check, release with parity_done.
    drive(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0);
    idle(3);

    // Port 1 busy: wait until empty; then again with soft reset (and a
    // soft reset on a foreign port that must be ignored).
    drive(1'b1, 2'd1, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 3'b101, 3'b001, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    idle(4);
    drive(1'b1, 2'd1, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 3'b101, 3'b010, 1'b0, 1'b0);
    idle(2);

    // Invalid address holds in decode.
    drive(1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 1'b0, 3'b111, 3'b111, 1'b0, 1'b0);
    idle(2);

    // Asynchronous reset in the middle of the payload.
    drive(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check_now("async_reset_mid_load", 8'b1000_0000);
    @(negedge clock);
    resetn = 1'b1;
    idle(2);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(3, 0) != 0), 2'($urandom_range(3, 0)),
            ($urandom_range(3, 0) == 0), 3'($urandom_range(7, 0)),
            {($urandom_range(15, 0) == 0), ($urandom_range(15, 0) == 0),
             ($urandom_range(15, 0) == 0)},
            ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0));
      if ($urandom_range(299, 0) == 0) resetn = 1'b0;
      else resetn = 1'b1;
    end
    resetn = 1'b1;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
